// File: rtl/hazard_scoreboard_if.sv
// Bundles the ID-stage request, the freeze/clear controls and the tracked
// pipeline state that the hazard scoreboard reports back to the pipeline.
interface hazard_scoreboard_if;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        id_branch;
   logic        mem_wait;
   logic        stat_clr;

   logic [4:0]  ID_EX_rd;
   logic [4:0]  EX_MEM_rd;
   logic [4:0]  MEM_WB_rd;
   logic        ID_EX_reg_write;
   logic        EX_MEM_reg_write;
   logic        MEM_WB_reg_write;
   logic        ID_EX_mem_read;
   logic        EX_MEM_mem_read;
   logic        stall;
   logic        bubble;
   logic [15:0] stall_count;

   // The pipeline control side drives requests and observes the scoreboard.
   modport master (
      output id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
             id_branch, mem_wait, stat_clr,
      input  ID_EX_rd, EX_MEM_rd, MEM_WB_rd,
             ID_EX_reg_write, EX_MEM_reg_write, MEM_WB_reg_write,
             ID_EX_mem_read, EX_MEM_mem_read, stall, bubble, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
             id_branch, mem_wait, stat_clr,
      output ID_EX_rd, EX_MEM_rd, MEM_WB_rd,
             ID_EX_reg_write, EX_MEM_reg_write, MEM_WB_reg_write,
             ID_EX_mem_read, EX_MEM_mem_read, stall, bubble, stall_count
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers through ID/EX, EX/MEM and MEM/WB and raises
// load-use and branch stalls. Optional stall statistics: HAZARD_STATS_EN.
module hazard_scoreboard (
   input logic               clk,
   input logic               rst_n,
   hazard_scoreboard_if.slave sb
);

   typedef struct packed {
      logic [4:0] rd;
      logic       reg_write;
      logic       mem_read;
   } entry_t;

   entry_t     id_ex;
   entry_t     ex_mem;
   logic [4:0] mem_wb_rd;
   logic       mem_wb_reg_write;

   logic rs_used;
   logic rt_used;
   logic match_id_ex;
   logic match_ex_mem;
   logic hz_lu;
   logic hz_br;
   logic stall_int;
   logic bubble_int;

   // Register 0 is hardwired, so a zero source or destination never forms a dependency.
   always_comb begin
      rs_used      = (sb.id_rs != 5'd0);
      rt_used      = (sb.id_rt != 5'd0);
      match_id_ex  = (id_ex.rd != 5'd0) &&
                     ((rs_used && (id_ex.rd == sb.id_rs)) ||
                      (rt_used && (id_ex.rd == sb.id_rt)));
      match_ex_mem = (ex_mem.rd != 5'd0) &&
                     ((rs_used && (ex_mem.rd == sb.id_rs)) ||
                      (rt_used && (ex_mem.rd == sb.id_rt)));
   end

   // Branches resolve in ID, so they also wait on ALU results still in EX and loads in MEM.
   always_comb begin
      hz_lu = sb.id_valid & id_ex.mem_read & match_id_ex;
      hz_br = sb.id_valid & sb.id_branch &
              ((id_ex.reg_write & match_id_ex) |
               (ex_mem.mem_read & match_ex_mem));
   end

   // A memory freeze suppresses the bubble; the hazard is re-examined once the pipe moves.
   always_comb begin
      stall_int  = rst_n & (sb.mem_wait | hz_lu | hz_br);
      bubble_int = rst_n & ~sb.mem_wait & (hz_lu | hz_br);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_ex            <= '0;
         ex_mem           <= '0;
         mem_wb_rd        <= 5'd0;
         mem_wb_reg_write <= 1'b0;
      end else if (!sb.mem_wait) begin
         mem_wb_rd        <= ex_mem.rd;
         mem_wb_reg_write <= ex_mem.reg_write;
         ex_mem           <= id_ex;
         if (sb.id_valid && !bubble_int) begin
            id_ex.rd        <= sb.id_rd;
            id_ex.reg_write <= sb.id_reg_write;
            id_ex.mem_read  <= sb.id_mem_read;
         end else begin
            id_ex <= '0;
         end
      end
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_count_q;

   // Counts bubble cycles, saturating rather than wrapping; a clear always wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_q <= 16'd0;
      end else if (sb.stat_clr) begin
         stall_count_q <= 16'd0;
      end else if (bubble_int && (stall_count_q != 16'hFFFF)) begin
         stall_count_q <= stall_count_q + 16'd1;
      end
   end

   assign sb.stall_count = stall_count_q;
`else
   logic unused_stat_clr;

   assign unused_stat_clr = sb.stat_clr;
   assign sb.stall_count  = 16'd0;
`endif

   assign sb.ID_EX_rd         = id_ex.rd;
   assign sb.ID_EX_reg_write  = id_ex.reg_write;
   assign sb.ID_EX_mem_read   = id_ex.mem_read;
   assign sb.EX_MEM_rd        = ex_mem.rd;
   assign sb.EX_MEM_reg_write = ex_mem.reg_write;
   assign sb.EX_MEM_mem_read  = ex_mem.mem_read;
   assign sb.MEM_WB_rd        = mem_wb_rd;
   assign sb.MEM_WB_reg_write = mem_wb_reg_write;
   assign sb.stall            = stall_int;
   assign sb.bubble           = bubble_int;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard: load-use, branch, freeze,
// reset and statistics cases with hand-computed expectations.
module tb_hazard_scoreboard;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   exp_count;

`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   hazard_scoreboard_if hif ();

   hazard_scoreboard dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sb    (hif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic rw, input logic mr,
                                input logic br, input logic mw);
      hif.id_valid     = v;
      hif.id_rs        = rs;
      hif.id_rt        = rt;
      hif.id_rd        = rd;
      hif.id_reg_write = rw;
      hif.id_mem_read  = mr;
      hif.id_branch    = br;
      hif.mem_wait     = mw;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic logic [15:0] expStat(input int n);
      return STATS ? n[15:0] : 16'd0;
   endfunction

   initial begin
      total     = 0;
      bad       = 0;
      exp_count = 0;
      rst_n     = 1'b0;
      hif.stat_clr = 1'b0;
      applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Reset state, with mem_wait high to prove stall is forced low
      #2;
      checkOutput("rst_stall", {15'd0, hif.stall}, 16'd0);
      checkOutput("rst_bubble", {15'd0, hif.bubble}, 16'd0);
      checkOutput("rst_idex_rd", {11'd0, hif.ID_EX_rd}, 16'd0);
      checkOutput("rst_mwb_rd", {11'd0, hif.MEM_WB_rd}, 16'd0);
      checkOutput("rst_count", hif.stall_count, 16'd0);
      tick();
      #2 rst_n = 1'b1;
      #1;
      checkOutput("memwait_stall", {15'd0, hif.stall}, 16'd1);
      checkOutput("memwait_bubble", {15'd0, hif.bubble}, 16'd0);
      idle(2);

      // Load followed by dependent ALU op: one bubble, then accept
      applyStimulus(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("lw_nostall", {15'd0, hif.stall}, 16'd0);
      tick();
      checkOutput("lw_idex_rd", {11'd0, hif.ID_EX_rd}, 16'd5);
      checkOutput("lw_idex_mr", {15'd0, hif.ID_EX_mem_read}, 16'd1);
      applyStimulus(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_stall", {15'd0, hif.stall}, 16'd1);
      checkOutput("lu_bubble", {15'd0, hif.bubble}, 16'd1);
      tick();
      exp_count += 1;
      checkOutput("lu_exmem_rd", {11'd0, hif.EX_MEM_rd}, 16'd5);
      checkOutput("lu_exmem_mr", {15'd0, hif.EX_MEM_mem_read}, 16'd1);
      checkOutput("lu_idex_nop", {11'd0, hif.ID_EX_rd}, 16'd0);
      checkOutput("lu_released", {15'd0, hif.stall}, 16'd0);
      tick();
      checkOutput("add_idex_rd", {11'd0, hif.ID_EX_rd}, 16'd7);
      checkOutput("add_idex_rw", {15'd0, hif.ID_EX_reg_write}, 16'd1);
      checkOutput("lw_memwb_rd", {11'd0, hif.MEM_WB_rd}, 16'd5);
      checkOutput("lw_memwb_rw", {15'd0, hif.MEM_WB_reg_write}, 16'd1);
      idle(1);
      checkOutput("nop_memwb_rd", {11'd0, hif.MEM_WB_rd}, 16'd0);
      checkOutput("add_exmem_rd", {11'd0, hif.EX_MEM_rd}, 16'd7);
      idle(3);

      // An invalid ID slot never hazards
      applyStimulus(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 5'd5, 5'd5, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("invalid_stall", {15'd0, hif.stall}, 16'd0);
      idle(3);

      // ALU op followed by dependent branch: one bubble
      applyStimulus(1'b1, 5'd1, 5'd2, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("add8_nostall", {15'd0, hif.stall}, 16'd0);
      tick();
      applyStimulus(1'b1, 5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("br_alu_bubble", {15'd0, hif.bubble}, 16'd1);
      tick();
      exp_count += 1;
      checkOutput("br_alu_exmem", {11'd0, hif.EX_MEM_rd}, 16'd8);
      checkOutput("br_alu_release", {15'd0, hif.stall}, 16'd0);
      checkOutput("count_two", hif.stall_count, expStat(exp_count));
      tick();
      idle(3);

      hif.stat_clr = 1'b1;
      tick();
      hif.stat_clr = 1'b0;
      exp_count = 0;
      checkOutput("clr_count", hif.stall_count, 16'd0);

      // Load followed by dependent branch: two bubbles
      applyStimulus(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("br_lw_bub1", {15'd0, hif.bubble}, 16'd1);
      tick();
      checkOutput("br_lw_bub2", {15'd0, hif.bubble}, 16'd1);
      checkOutput("br_lw_exmem", {11'd0, hif.EX_MEM_rd}, 16'd3);
      tick();
      exp_count += 2;
      checkOutput("br_lw_done", {15'd0, hif.stall}, 16'd0);
      checkOutput("count_lw_br", hif.stall_count, expStat(exp_count));
      tick();
      idle(3);

      // Memory freeze during a load-use hazard
      applyStimulus(1'b1, 5'd1, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd4, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("frz_stall", {15'd0, hif.stall}, 16'd1);
         checkOutput("frz_bubble", {15'd0, hif.bubble}, 16'd0);
         tick();
         checkOutput("frz_idex_rd", {11'd0, hif.ID_EX_rd}, 16'd4);
         checkOutput("frz_idex_mr", {15'd0, hif.ID_EX_mem_read}, 16'd1);
         checkOutput("frz_exmem_rd", {11'd0, hif.EX_MEM_rd}, 16'd0);
      end
      applyStimulus(1'b1, 5'd4, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("thaw_bubble", {15'd0, hif.bubble}, 16'd1);
      tick();
      exp_count += 1;
      checkOutput("thaw_exmem_rd", {11'd0, hif.EX_MEM_rd}, 16'd4);
      checkOutput("thaw_idex_nop", {11'd0, hif.ID_EX_rd}, 16'd0);
      checkOutput("thaw_stall", {15'd0, hif.stall}, 16'd0);
      checkOutput("count_frz", hif.stall_count, expStat(exp_count));
      tick();
      checkOutput("thaw_add_rd", {11'd0, hif.ID_EX_rd}, 16'd10);
      idle(3);

      // Register 0 never hazards
      applyStimulus(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("r0_stall", {15'd0, hif.stall}, 16'd0);
      checkOutput("r0_bubble", {15'd0, hif.bubble}, 16'd0);
      tick();
      checkOutput("r0_accept", {11'd0, hif.ID_EX_rd}, 16'd9);
      idle(3);

      // Asynchronous reset in the middle of a stall
      applyStimulus(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("pre_rst_bubble", {15'd0, hif.bubble}, 16'd1);
      #2 rst_n = 1'b0;
      #1;
      exp_count = 0;
      checkOutput("mid_rst_stall", {15'd0, hif.stall}, 16'd0);
      checkOutput("mid_rst_bubble", {15'd0, hif.bubble}, 16'd0);
      checkOutput("mid_rst_idex", {11'd0, hif.ID_EX_rd}, 16'd0);
      checkOutput("mid_rst_idex_mr", {15'd0, hif.ID_EX_mem_read}, 16'd0);
      checkOutput("mid_rst_count", hif.stall_count, 16'd0);
      #2 rst_n = 1'b1;
      #1;
      checkOutput("post_rst_stall", {15'd0, hif.stall}, 16'd0);
      tick();
      checkOutput("post_rst_accept", {11'd0, hif.ID_EX_rd}, 16'd7);
      idle(3);

`ifdef HAZARD_STATS_EN
      // Saturation: two bubbles per three cycles until the counter pegs
      for (int i = 0; i < 32769; i++) begin
         applyStimulus(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
         tick();
         applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
         tick();
         tick();
      end
      checkOutput("sat_count", hif.stall_count, 16'hFFFF);
      idle(3);
`endif

      // A clear coinciding with a bubble wins over the increment
      applyStimulus(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      hif.stat_clr = 1'b1;
      #1;
      checkOutput("clr_bubble", {15'd0, hif.bubble}, 16'd1);
      tick();
      hif.stat_clr = 1'b0;
      checkOutput("clr_with_bubble", hif.stall_count, 16'd0);
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
